// File: rtl/washer_pkg.sv
// Shared encodings and widths for the washer program sequencer.
package washer_pkg;

    localparam int unsigned REMAIN_W = 8;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_PAUSE = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'd0,
        MODE_QUICK = 2'd1,
        MODE_SPIN  = 2'd2
    } mode_t;

    // Program selection cycles full -> quick -> spin-only -> full.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_FULL:  n = MODE_QUICK;
            MODE_QUICK: n = MODE_SPIN;
            default:    n = MODE_FULL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for one debounced key level.
module key_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic rise
);

    logic prev;

    // Previous-sample flop for the key level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= key;
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/washer_ctrl.sv
// Washing-machine program sequencer: key handling, phase FSM, seconds
// timer, motor reversal and registered actuator drive.
module washer_ctrl
    import washer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned WASH_DEF  = 10,
    parameter int unsigned WASH_STEP = 5,
    parameter int unsigned WASH_MAX  = 60,
    parameter int unsigned RINSE_SEC = 10,
    parameter int unsigned SPIN_SEC  = 8,
    parameter int unsigned DIR_SEC   = 2,
    parameter int unsigned BUZZ_SEC  = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start_key,
    input  logic                add_key,
    input  logic                mode_key,
    output logic [1:0]          mode,
    output logic [2:0]          phase,
    output logic [REMAIN_W-1:0] remain,
    output logic                motor_fwd,
    output logic                motor_rev,
    output logic                valve_in,
    output logic                pump_out,
    output logic                buzzer
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DIR_W  = $clog2(2 * DIR_SEC);

    logic start_e, add_e, mode_e;

    key_edge u_start (.clock(clock), .reset_n(reset_n), .key(start_key), .rise(start_e));
    key_edge u_add   (.clock(clock), .reset_n(reset_n), .key(add_key),   .rise(add_e));
    key_edge u_mode  (.clock(clock), .reset_n(reset_n), .key(mode_key),  .rise(mode_e));

    phase_t              phase_q, phase_d, saved_q, saved_d;
    mode_t               mode_q, mode_d;
    logic [REMAIN_W-1:0] wash_q, wash_d, remain_q, remain_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic                fwd_d, rev_d, valve_d, pump_d, buzz_d;

    logic                enter;
    phase_t              enter_ph;
    logic                tick_term;
    logic [REMAIN_W:0]   wash_sum;

    // Duration loaded into remain when a phase is entered.
    function automatic logic [REMAIN_W-1:0] phase_len(input phase_t p,
                                                      input logic [REMAIN_W-1:0] w);
        logic [REMAIN_W-1:0] len;
        case (p)
            PH_WASH:  len = w;
            PH_RINSE: len = REMAIN_W'(RINSE_SEC);
            PH_SPIN:  len = REMAIN_W'(SPIN_SEC);
            PH_DONE:  len = REMAIN_W'(BUZZ_SEC);
            default:  len = w;
        endcase
        return len;
    endfunction

    assign tick_term = (tick_q == TICK_W'(TICK_DIV - 1));
    assign wash_sum  = {1'b0, wash_q} + (REMAIN_W + 1)'(WASH_STEP);

    // Next-state logic for phase, timers, settings and actuators.
    always_comb begin
        phase_d  = phase_q;
        saved_d  = saved_q;
        mode_d   = mode_q;
        wash_d   = wash_q;
        remain_d = remain_q;
        tick_d   = tick_q;
        dir_d    = dir_q;
        enter    = 1'b0;
        enter_ph = PH_IDLE;

        case (phase_q)
            PH_IDLE: begin
                if (start_e) begin
                    enter    = 1'b1;
                    enter_ph = (mode_q == MODE_SPIN) ? PH_SPIN : PH_WASH;
                end else begin
                    if (add_e) begin
                        if (wash_sum > (REMAIN_W + 1)'(WASH_MAX))
                            wash_d = REMAIN_W'(WASH_MAX);
                        else
                            wash_d = wash_sum[REMAIN_W-1:0];
                    end else if (mode_e) begin
                        mode_d = next_mode(mode_q);
                    end
                    remain_d = wash_d;
                end
            end
            PH_WASH, PH_RINSE, PH_SPIN, PH_DONE: begin
                if (start_e) begin
                    if (phase_q == PH_DONE) begin
                        enter    = 1'b1;
                        enter_ph = PH_IDLE;
                    end else begin
                        saved_d = phase_q;
                        phase_d = PH_PAUSE;
                    end
                end else begin
                    tick_d = tick_term ? '0 : tick_q + 1'b1;
                    if (tick_term) begin
                        if (phase_q == PH_WASH || phase_q == PH_RINSE)
                            dir_d = (dir_q == DIR_W'(2 * DIR_SEC - 1)) ? '0 : dir_q + 1'b1;
                        if (remain_q == REMAIN_W'(1)) begin
                            enter = 1'b1;
                            case (phase_q)
                                PH_WASH:  enter_ph = (mode_q == MODE_FULL) ? PH_RINSE : PH_SPIN;
                                PH_RINSE: enter_ph = PH_SPIN;
                                PH_SPIN:  enter_ph = PH_DONE;
                                default:  enter_ph = PH_IDLE;
                            endcase
                        end else begin
                            remain_d = remain_q - 1'b1;
                        end
                    end
                end
            end
            PH_PAUSE: begin
                if (start_e) phase_d = saved_q;
            end
            default: phase_d = PH_IDLE;
        endcase

        if (enter) begin
            phase_d  = enter_ph;
            tick_d   = '0;
            dir_d    = '0;
            remain_d = phase_len(enter_ph, wash_q);
        end

        // Actuators follow the upcoming state so they register alongside it.
        fwd_d   = 1'b0;
        rev_d   = 1'b0;
        valve_d = 1'b0;
        pump_d  = 1'b0;
        buzz_d  = 1'b0;
        case (phase_d)
            PH_WASH, PH_RINSE: begin
                fwd_d   = (dir_d <  DIR_W'(DIR_SEC));
                rev_d   = (dir_d >= DIR_W'(DIR_SEC));
                valve_d = (phase_d == PH_RINSE);
            end
            PH_SPIN: begin
                fwd_d  = 1'b1;
                pump_d = 1'b1;
            end
            PH_DONE: buzz_d = 1'b1;
            default: ;
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_IDLE;
            saved_q   <= PH_IDLE;
            mode_q    <= MODE_FULL;
            wash_q    <= REMAIN_W'(WASH_DEF);
            remain_q  <= REMAIN_W'(WASH_DEF);
            tick_q    <= '0;
            dir_q     <= '0;
            motor_fwd <= 1'b0;
            motor_rev <= 1'b0;
            valve_in  <= 1'b0;
            pump_out  <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            saved_q   <= saved_d;
            mode_q    <= mode_d;
            wash_q    <= wash_d;
            remain_q  <= remain_d;
            tick_q    <= tick_d;
            dir_q     <= dir_d;
            motor_fwd <= fwd_d;
            motor_rev <= rev_d;
            valve_in  <= valve_d;
            pump_out  <= pump_d;
            buzzer    <= buzz_d;
        end
    end

    assign phase  = phase_q;
    assign mode   = mode_q;
    assign remain = remain_q;

endmodule
